// File: rtl/ldm_stm_sequencer_if.sv
// Block-transfer bus of the LDM/STM sequencer: request, status, memory-file
// and register-file controls. The sequencer is the master of this bus.
interface ldm_stm_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 16
);
  localparam int IDX_W = $clog2(NREGS);

  logic              start;
  logic              is_load;
  logic [NREGS-1:0]  reg_list;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_value;
  logic              mem_ldr_str_en;
  logic              mem_load_en;
  logic              mem_store_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_i;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic [IDX_W-1:0]  rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic              rf_write_en;
  logic [IDX_W-1:0]  rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;

  modport master (
    input  start, is_load, reg_list, base_addr, mem_read_data, rf_read_data,
    output busy, done, wb_valid, wb_value,
    output mem_ldr_str_en, mem_load_en, mem_store_en, mem_addr, mem_i, mem_write_data,
    output rf_read_addr, rf_write_en, rf_write_addr, rf_write_data
  );

  modport slave (
    output start, is_load, reg_list, base_addr, mem_read_data, rf_read_data,
    input  busy, done, wb_valid, wb_value,
    input  mem_ldr_str_en, mem_load_en, mem_store_en, mem_addr, mem_i, mem_write_data,
    input  rf_read_addr, rf_write_en, rf_write_addr, rf_write_data
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a register list lowest-bit first,
// one memory access per cycle, with loads written back one cycle later.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_STORE    | one register -> memory per cycle
// S_LOAD     | one memory read issued per cycle, previous read written to rf
// S_LOAD_DRAIN | final rf write of the last load
// S_DONE     | done / writeback pulse, back to idle
module ldm_stm_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 16
) (
  input logic clk,
  input logic rst,
  ldm_stm_sequencer_if.master bus
);
  localparam int IDX_W = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_IDLE, S_STORE, S_LOAD, S_LOAD_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NREGS-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] wb_q, wb_d;
  logic              pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;

  logic [IDX_W-1:0]  cur_idx;
  logic              cur_found;
  logic [NREGS-1:0]  remaining_clr;
  logic              last_xfer;
  logic [ADDR_W-1:0] list_cnt;

  // Lowest set bit of the remaining list is the register handled this cycle.
  always_comb begin
    cur_idx   = '0;
    cur_found = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (remaining_q[i] && !cur_found) begin
        cur_idx   = IDX_W'(i);
        cur_found = 1'b1;
      end
    end
    remaining_clr = remaining_q & ~(NREGS'(1) << cur_idx);
    last_xfer     = (remaining_clr == '0);
  end

  always_comb begin
    list_cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      list_cnt = list_cnt + ADDR_W'(bus.reg_list[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    offset_d     = offset_q;
    base_d       = base_q;
    wb_d         = wb_q;
    pend_valid_d = 1'b0;
    pend_idx_d   = pend_idx_q;

    bus.busy           = (state_q != S_IDLE);
    bus.done           = 1'b0;
    bus.wb_valid       = 1'b0;
    bus.wb_value       = '0;
    bus.mem_ldr_str_en = 1'b0;
    bus.mem_load_en    = 1'b0;
    bus.mem_store_en   = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_i          = '0;
    bus.mem_write_data = '0;
    bus.rf_read_addr   = '0;
    // Only a load issued in the previous cycle produces a register write.
    bus.rf_write_en    = pend_valid_q;
    bus.rf_write_addr  = pend_valid_q ? pend_idx_q : '0;
    bus.rf_write_data  = pend_valid_q ? bus.mem_read_data : '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          remaining_d = bus.reg_list;
          offset_d    = '0;
          base_d      = bus.base_addr;
          wb_d        = bus.base_addr + list_cnt;
          if (bus.reg_list == '0) state_d = S_DONE;
          else if (bus.is_load)   state_d = S_LOAD;
          else                    state_d = S_STORE;
        end
      end
      S_STORE: begin
        bus.mem_ldr_str_en = 1'b1;
        bus.mem_store_en   = 1'b1;
        bus.mem_addr       = base_q;
        bus.mem_i          = offset_q;
        bus.rf_read_addr   = cur_idx;
        bus.mem_write_data = bus.rf_read_data;
        remaining_d        = remaining_clr;
        offset_d           = offset_q + 1'b1;
        if (last_xfer) state_d = S_DONE;
      end
      S_LOAD: begin
        bus.mem_ldr_str_en = 1'b1;
        bus.mem_load_en    = 1'b1;
        bus.mem_addr       = base_q;
        bus.mem_i          = offset_q;
        pend_valid_d       = 1'b1;
        pend_idx_d         = cur_idx;
        remaining_d        = remaining_clr;
        offset_d           = offset_q + 1'b1;
        if (last_xfer) state_d = S_LOAD_DRAIN;
      end
      S_LOAD_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        bus.done     = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_value = wb_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      offset_q     <= '0;
      base_q       <= '0;
      wb_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      offset_q     <= offset_d;
      base_q       <= base_d;
      wb_q         <= wb_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
    end
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: stimulus pushes expected strobes,
// a negedge monitor pops and compares each strobe the sequencer presents.
module tb_ldm_stm_sequencer;
  localparam int K_STORE = 0;
  localparam int K_LOAD  = 1;
  localparam int K_RFW   = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    int          a;
    logic [31:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  ev_t  exp_q[$];

  logic [31:0] mem_m [16];
  logic [31:0] rf_m  [16];

  ldm_stm_sequencer_if #(.DATA_W(32), .ADDR_W(8), .NREGS(16)) bus ();

  ldm_stm_sequencer #(.DATA_W(32), .ADDR_W(8), .NREGS(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory file and register file models.
  logic [3:0] mem_loc;
  assign mem_loc = bus.mem_addr[3:0] + bus.mem_i[3:0];
  assign bus.rf_read_data = rf_m[bus.rf_read_addr];

  always @(posedge clk) begin
    if (bus.mem_store_en) mem_m[mem_loc] <= bus.mem_write_data;
    bus.mem_read_data <= bus.mem_load_en ? mem_m[mem_loc] : 32'h0;
    if (bus.rf_write_en) rf_m[bus.rf_write_addr] <= bus.rf_write_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic push_ev(input int kind, input int c, input int a, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // Expected strobe sequence of one full transfer started at the edge after cycle c.
  task automatic push_txn(input bit il, input logic [15:0] list, input logic [7:0] base, input int c);
    int idx[$];
    int n;
    int wb;
    for (int i = 0; i < 16; i++) if (list[i]) idx.push_back(i);
    n  = idx.size();
    wb = (int'(base) + n) & 255;
    if (n == 0) begin
      push_ev(K_DONE, c + 1, wb, 32'd3);
    end else if (!il) begin
      for (int k = 0; k < n; k++)
        push_ev(K_STORE, c + 1 + k, int'(base) * 256 + k, rf_m[idx[k]]);
      push_ev(K_DONE, c + n + 1, wb, 32'd3);
    end else begin
      for (int k = 0; k <= n; k++) begin
        if (k < n) push_ev(K_LOAD, c + 1 + k, int'(base) * 256 + k, 32'd0);
        if (k > 0) push_ev(K_RFW, c + 1 + k, idx[k-1], mem_m[(int'(base) + k - 1) & 15]);
      end
      push_ev(K_DONE, c + n + 2, wb, 32'd3);
    end
  endtask

  task automatic obs(input int kind, input int a, input logic [31:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d a=0x%0h d=0x%0h at cycle %0d, expected none", kind, a, d, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind == kind && e.cyc == cyc && e.a == a && e.d == d) n_pass++;
    else $display("FAIL event: got kind %0d cyc %0d a=0x%0h d=0x%0h, expected kind %0d cyc %0d a=0x%0h d=0x%0h",
                  kind, cyc, a, d, e.kind, e.cyc, e.a, e.d);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_store_en) obs(K_STORE, int'(bus.mem_addr) * 256 + int'(bus.mem_i), bus.mem_write_data);
      if (bus.mem_load_en)  obs(K_LOAD, int'(bus.mem_addr) * 256 + int'(bus.mem_i), 32'd0);
      if (bus.rf_write_en)  obs(K_RFW, int'(bus.rf_write_addr), bus.rf_write_data);
      if (bus.done)         obs(K_DONE, int'(bus.wb_value), {30'd0, bus.wb_valid, bus.busy});
      if (bus.mem_ldr_str_en || bus.mem_load_en || bus.mem_store_en)
        chk("strobe_exclusive",
            int'(!(bus.mem_load_en && bus.mem_store_en) && bus.mem_ldr_str_en &&
                 !(bus.mem_store_en && bus.rf_write_en)), 1);
    end
  end

  task automatic run(input bit il, input logic [15:0] list, input logic [7:0] base);
    int c;
    @(negedge clk);
    c = cyc;
    bus.start = 1'b1; bus.is_load = il; bus.reg_list = list; bus.base_addr = base;
    push_txn(il, list, base, c);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.is_load   = ~il;
    bus.reg_list  = 16'($urandom);
    bus.base_addr = 8'($urandom);
    chk("busy_cycle1", int'(bus.busy), 1);
    repeat ($countones(list) + 3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("busy_idle", int'(bus.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    for (int i = 0; i < 16; i++) begin
      rf_m[i]  = 32'(100 + i);
      mem_m[i] = 32'(200 + i);
    end
    rf_m[0] = 32'd11; rf_m[2] = 32'd22; rf_m[4] = 32'd33;
    mem_m[0] = 32'd5; mem_m[1] = 32'd6; mem_m[2] = 32'd7;
    rst = 1'b1;
    bus.start = 1'b0; bus.is_load = 1'b0; bus.reg_list = '0; bus.base_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        int'({bus.busy, bus.done, bus.wb_valid, bus.mem_ldr_str_en, bus.mem_load_en,
              bus.mem_store_en, bus.rf_write_en}), 0);
    chk("reset_buses", int'(bus.wb_value | bus.mem_addr | bus.mem_i), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Store r0,r2,r4 to base 4.
    run(1'b0, 16'h0015, 8'h04);
    chk("store_mem4", int'(mem_m[4]), 11);
    chk("store_mem5", int'(mem_m[5]), 22);
    chk("store_mem6", int'(mem_m[6]), 33);

    // Load r0,r1,r15 from base 0.
    run(1'b1, 16'h8003, 8'h00);
    chk("load_r0", int'(rf_m[0]), 5);
    chk("load_r1", int'(rf_m[1]), 6);
    chk("load_r15", int'(rf_m[15]), 7);

    // Empty list.
    run(1'b1, 16'h0000, 8'h3C);

    // Full store with wrap: mem[k] = r[(k-8) mod 16].
    run(1'b0, 16'hFFFF, 8'h08);
    chk("full_mem0_r8", int'(mem_m[0]), 108);
    chk("full_mem7_r15", int'(mem_m[7]), 7);
    chk("full_mem8_r0", int'(mem_m[8]), 5);

    // start held high through a whole load and into the following idle cycle.
    @(negedge clk);
    c = cyc;
    bus.start = 1'b1; bus.is_load = 1'b1; bus.reg_list = 16'h00F0; bus.base_addr = 8'h00;
    push_txn(1'b1, 16'h00F0, 8'h00, c);
    repeat (7) @(negedge clk);
    chk("busy_idle_gap", int'(bus.busy), 0);
    push_txn(1'b1, 16'h00F0, 8'h00, c + 7);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("repeat_start_drained", exp_q.size(), 0);
    chk("load_r4", int'(rf_m[4]), 108);
    chk("load_r7", int'(rf_m[7]), 111);

    // Reset during cycle 2 of a 4-register load.
    @(negedge clk);
    c = cyc;
    bus.start = 1'b1; bus.is_load = 1'b1; bus.reg_list = 16'h000F; bus.base_addr = 8'h00;
    push_ev(K_LOAD, c + 1, 0, 32'd0);
    push_ev(K_LOAD, c + 2, 1, 32'd0);
    push_ev(K_RFW,  c + 2, 0, mem_m[0]);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quiet",
        int'({bus.busy, bus.done, bus.mem_ldr_str_en, bus.mem_load_en,
              bus.mem_store_en, bus.rf_write_en}), 0);
    repeat (4) @(negedge clk);
    chk("abort_drained", exp_q.size(), 0);
    chk("abort_r0", int'(rf_m[0]), 108);
    chk("abort_r1", int'(rf_m[1]), 6);

    // Normal store after the abort.
    run(1'b0, 16'h0003, 8'h20);
    chk("post_abort_mem0", int'(mem_m[0]), 108);
    chk("post_abort_mem1", int'(mem_m[1]), 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
